led_msg_scroller: RTL and testbench
===================================

Name: led_msg_scroller

Overview:
Upstream character source for the 4-digit LED display driver. It holds a 16-entry message of 4-bit character codes and presents a sliding 4-character window on char3..char0, with char3 feeding the an3 digit. The window advances one position every STEP_CYCLES clocks and wraps around the message end. The message can be rewritten at run time through a simple write port.

Parameters:
MSG_LEN, 16, number of message entries; must be a power of two, max 16.
CHAR_W, 4, bits per character code; matches the driver's digit input.
STEP_CYCLES, 50_000_000, clocks per scroll step; must be >= 2. Benches use 4.

Ports:
clk  in  1  system clock; all state updates on rising edge.
reset  in  1  asynchronous, active-high reset.
wr_en  in  1  write strobe for the message memory.
wr_addr  in  $clog2(MSG_LEN)  message entry to write.
wr_data  in  CHAR_W  character code to write.
pause  in  1  when high, freezes the scroll timer and the window position.
char3  out  CHAR_W  leftmost window character, mem[ptr].
char2  out  CHAR_W  mem[(ptr+1) mod MSG_LEN].
char1  out  CHAR_W  mem[(ptr+2) mod MSG_LEN].
char0  out  CHAR_W  rightmost window character, mem[(ptr+3) mod MSG_LEN].
step  out  1  one-cycle pulse on the cycle ptr advances.
ptr  out  $clog2(MSG_LEN)  current window start index.

Behaviour:
- Reset (asynchronous, any time, including mid-step):
  - mem[i] = i (default message 0,1,…,F).
  - ptr = 0, prescaler count = 0, step = 0.
  - char3..char0 = 0x0, 0x1, 0x2, 0x3.
  - The first step after reset release fires exactly STEP_CYCLES clocks later.
- Prescaler:
  - Counts 0..STEP_CYCLES-1, then wraps to 0.
  - The terminal-count cycle (count == STEP_CYCLES-1 with pause low) is the step cycle.
  - While pause is high, the count holds. It resumes from the held value, so the total unpaused cycles between steps is always STEP_CYCLES.
- Step cycle:
  - ptr <= (ptr+1) mod MSG_LEN; wraps from MSG_LEN-1 to 0.
  - The step output is registered and is high in the cycle after the terminal-count edge, coincident with the new ptr value.
- Window outputs:
  - Registered, recomputed every cycle from the current ptr and memory contents.
  - Latency: one clock after a ptr change or a memory write.
  - Window indices wrap modulo MSG_LEN. Example: ptr = 14 gives mem[14], mem[15], mem[0], mem[1].
- Writes:
  - mem[wr_addr] <= wr_data on the edge where wr_en = 1.
  - Accepted at any time, including while paused.
  - No back-pressure; every write is accepted.
- Simultaneous write and step: both take effect on the same edge. The next window uses the new ptr and the new data.
- Writing the same address on consecutive cycles: last write wins.
- pause asserted on the terminal-count cycle: no step occurs; the count holds at STEP_CYCLES-1.

Optional Feature:
LED_SCROLL_DIR_EN
- Defined: adds input port dir (1 bit). When dir = 1, a step decrements ptr (0 wraps to MSG_LEN-1). When dir = 0, ptr increments. dir is sampled on the step cycle only.
- Undefined: the dir port is absent and scrolling is forward only. Behaviour is identical to the defined case with dir = 0.

Decomposition:
- Shared package (led_pkg):
  - CHAR_W and MSG_LEN constants.
  - Pointer width constant.
  - Default message constant, used by both the reset initialisation and the bench scoreboard.
- One sub-module, led_step_timer: the prescaler with pause. It outputs the terminal-count strobe.
- Memory, pointer and window registers stay in led_msg_scroller.

Test Plan:
1. Reset check (STEP_CYCLES = 4): pulse reset high for 10 ns, release → char3..0 = 0,1,2,3 and ptr = 0; the first step pulse arrives 4 clocks after release, then ptr = 1 and chars read 1,2,3,4.
2. Wrap-around: run 14 steps → ptr = 14, chars = E,F,0,1; two more steps → ptr = 0 and chars = 0,1,2,3.
3. Pause: assert pause after 2 of 4 prescaler cycles, hold for 20 clocks, release → the step fires exactly 2 clocks after release and ptr increments by exactly 1.
4. Run-time write: write addr 5 = 0xA while ptr = 3 → one clock later char1 = 0xA; the other characters are unchanged.
5. Simultaneous events: write addr 4 = 0xC on the step edge from ptr 3 to 4 → the next cycle shows char3 = 0xC with ptr = 4.
6. Asynchronous reset mid-run: assert reset at ptr = 9 between clock edges → outputs return to 0,1,2,3 and ptr = 0 before the next edge; the written value at addr 5 is restored to 5. With LED_SCROLL_DIR_EN defined and dir = 1 from ptr = 0, one step gives ptr = 15 and chars F,0,1,2.

Source files
------------

// File: rtl/led_pkg.sv
// Shared constants for the LED message scroller: character width, message
// length, pointer width and the power-on message (0,1,...,F).
package led_pkg;

  localparam int CHAR_W  = 4;
  localparam int MSG_LEN = 16;
  localparam int PTR_W   = $clog2(MSG_LEN);

  // Entry i holds character code i; used at reset and by the bench.
  localparam logic [15:0][3:0] DEFAULT_MSG = {
    4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8,
    4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0
  };

endpackage

// File: rtl/led_step_timer.sv
// Scroll prescaler: counts unpaused clocks 0..STEP_CYCLES-1 and flags the
// terminal-count cycle. The count holds while pause is high.
module led_step_timer #(
  parameter int STEP_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pause,
  output logic o_tc
);

  localparam int CNT_W = $clog2(STEP_CYCLES);

  logic [CNT_W-1:0] r_count;
  logic             w_tc;

  // Pausing on the terminal cycle suppresses the step and keeps the count.
  assign w_tc = (r_count == CNT_W'(STEP_CYCLES - 1)) && !pause;
  assign o_tc = w_tc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (!pause) begin
      r_count <= w_tc ? '0 : r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_msg_scroller.sv
// Message memory plus sliding 4-character window for the LED digit driver.
// Optional `LED_SCROLL_DIR_EN adds a dir input for reverse scrolling.
module led_msg_scroller
  import led_pkg::*;
#(
  parameter int MSG_LEN     = led_pkg::MSG_LEN,
  parameter int CHAR_W      = led_pkg::CHAR_W,
  parameter int STEP_CYCLES = 50_000_000,
  localparam int PW         = $clog2(MSG_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [PW-1:0]     wr_addr,
  input  logic [CHAR_W-1:0] wr_data,
  input  logic              pause,
`ifdef LED_SCROLL_DIR_EN
  input  logic              dir,
`endif
  output logic [CHAR_W-1:0] char3,
  output logic [CHAR_W-1:0] char2,
  output logic [CHAR_W-1:0] char1,
  output logic [CHAR_W-1:0] char0,
  output logic              step,
  output logic [PW-1:0]     ptr
);

  logic [CHAR_W-1:0] r_mem [MSG_LEN];
  logic [PW-1:0]     r_ptr;
  logic              r_step;
  logic [CHAR_W-1:0] r_char3, r_char2, r_char1, r_char0;
  logic              w_tc;

  led_step_timer #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .pause(pause),
    .o_tc (w_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        r_mem[i] <= CHAR_W'(DEFAULT_MSG[i]);
      end
    end else if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Power-of-two MSG_LEN lets the pointer wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr  <= '0;
      r_step <= 1'b0;
    end else begin
      r_step <= w_tc;
      if (w_tc) begin
`ifdef LED_SCROLL_DIR_EN
        r_ptr <= dir ? r_ptr - PW'(1) : r_ptr + PW'(1);
`else
        r_ptr <= r_ptr + PW'(1);
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_char3 <= CHAR_W'(DEFAULT_MSG[0]);
      r_char2 <= CHAR_W'(DEFAULT_MSG[1]);
      r_char1 <= CHAR_W'(DEFAULT_MSG[2]);
      r_char0 <= CHAR_W'(DEFAULT_MSG[3]);
    end else begin
      r_char3 <= r_mem[r_ptr];
      r_char2 <= r_mem[r_ptr + PW'(1)];
      r_char1 <= r_mem[r_ptr + PW'(2)];
      r_char0 <= r_mem[r_ptr + PW'(3)];
    end
  end

  assign char3 = r_char3;
  assign char2 = r_char2;
  assign char1 = r_char1;
  assign char0 = r_char0;
  assign step  = r_step;
  assign ptr   = r_ptr;

endmodule

// File: tb/tb_led_msg_scroller.sv
// Self-checking bench for led_msg_scroller with STEP_CYCLES = 4: scripted
// vectors, directed corner cases and randomized traffic against a model.
module tb_led_msg_scroller;
  import led_pkg::*;

  localparam int STEP = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic       pause = 1'b0;
`ifdef LED_SCROLL_DIR_EN
  logic       dir = 1'b0;
`endif
  logic [3:0] char3, char2, char1, char0, ptr;
  logic       step;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  led_msg_scroller #(
    .MSG_LEN(16), .CHAR_W(4), .STEP_CYCLES(STEP)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .pause(pause),
`ifdef LED_SCROLL_DIR_EN
    .dir(dir),
`endif
    .char3(char3), .char2(char2), .char1(char1), .char0(char0),
    .step(step), .ptr(ptr)
  );

  // Reference model: message array, window start, and number of unpaused
  // clocks since the last scroll step.
  logic [3:0]  m_mem [16];
  int          m_ptr;
  int          m_unpaused;
  logic [15:0] m_chars;
  logic        m_step;
  logic [3:0]  exp_q [$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) m_mem[i] = DEFAULT_MSG[i];
      m_ptr      = 0;
      m_unpaused = 0;
      m_chars    = 16'h0123;
      m_step     = 1'b0;
      exp_q.delete();
    end else begin
      m_chars = {m_mem[m_ptr], m_mem[(m_ptr + 1) % 16],
                 m_mem[(m_ptr + 2) % 16], m_mem[(m_ptr + 3) % 16]};
      if (wr_en) m_mem[wr_addr] = wr_data;
      m_step = 1'b0;
      if (!pause) begin
        m_unpaused++;
        if (m_unpaused == STEP) begin
          m_unpaused = 0;
          m_step     = 1'b1;
`ifdef LED_SCROLL_DIR_EN
          m_ptr = dir ? (m_ptr + 15) % 16 : (m_ptr + 1) % 16;
`else
          m_ptr = (m_ptr + 1) % 16;
`endif
          exp_q.push_back(4'(m_ptr));
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("ptr", 32'(ptr), 32'(m_ptr));
    chk("step", 32'(step), 32'(m_step));
    chk("chars", 32'({char3, char2, char1, char0}), 32'(m_chars));
    if (step) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL step_q: got unexpected step at ptr %0h", ptr);
      end else begin
        chk("step_q", 32'(ptr), 32'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  // Run until the model reports a step landing on ptr == target.
  task automatic run_to_step(input int target, input int budget);
    int k;
    k = 0;
    while (!(m_step && m_ptr == target) && k < budget) begin
      tick();
      k++;
    end
    n_tests++;
    if (!(m_step && m_ptr == target)) begin
      n_fail++;
      $display("FAIL wait_ptr: got ptr %0h expected step to %0h", ptr, target);
    end
  endtask

  typedef struct {
    int          cycles;
    logic        pause;
    logic [3:0]  ptr;
    logic [15:0] chars;
    logic        step;
  } vec_t;

  vec_t vecs [11];

  initial begin
    vecs[0]  = '{0,  1'b0, 4'h0, 16'h0123, 1'b0};  // reset state
    vecs[1]  = '{3,  1'b0, 4'h0, 16'h0123, 1'b0};
    vecs[2]  = '{1,  1'b0, 4'h1, 16'h0123, 1'b1};  // first step, 4 clocks
    vecs[3]  = '{1,  1'b0, 4'h1, 16'h1234, 0};
    vecs[4]  = '{1,  1'b0, 4'h1, 16'h1234, 0};     // 2 of 4 prescaler cycles
    vecs[5]  = '{20, 1'b1, 4'h1, 16'h1234, 0};     // paused
    vecs[6]  = '{1,  1'b0, 4'h1, 16'h1234, 0};
    vecs[7]  = '{1,  1'b0, 4'h2, 16'h1234, 1'b1};  // 2 clocks after release
    vecs[8]  = '{48, 1'b0, 4'hE, 16'hDEF0, 1'b1};  // 12 more steps
    vecs[9]  = '{1,  1'b0, 4'hE, 16'hEF01, 0};
    vecs[10] = '{7,  1'b0, 4'h0, 16'hF012, 1'b1};  // wrap 15 -> 0

    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      pause = vecs[i].pause;
      for (int k = 0; k < vecs[i].cycles; k++) tick();
      chk($sformatf("vec%0d_ptr", i), 32'(ptr), 32'(vecs[i].ptr));
      chk($sformatf("vec%0d_chars", i), 32'({char3, char2, char1, char0}), 32'(vecs[i].chars));
      chk($sformatf("vec%0d_step", i), 32'(step), 32'(vecs[i].step));
    end
    pause = 1'b0;
    tick();
    chk("wrap_settle", 32'({char3, char2, char1, char0}), 32'h0123);

    // Run-time write at ptr 3, then a write coincident with the 3 -> 4 step.
    run_to_step(3, 40);
    wr_en = 1'b1; wr_addr = 4'h5; wr_data = 4'hA;
    tick();
    wr_en = 1'b0;
    tick();
    chk("write_char1", 32'({char3, char2, char1, char0}), 32'h34A6);
    tick();
    wr_en = 1'b1; wr_addr = 4'h4; wr_data = 4'hC;
    tick();
    wr_en = 1'b0;
    chk("simul_ptr", 32'(ptr), 32'h4);
    chk("simul_step", 32'(step), 32'h1);
    tick();
    chk("simul_chars", 32'({char3, char2, char1, char0}), 32'hCA67);

    // Same address written back-to-back: last write wins.
    wr_en = 1'b1; wr_addr = 4'h6; wr_data = 4'h1;
    tick();
    wr_data = 4'h2;
    tick();
    wr_en = 1'b0;
    tick();

    // Asynchronous reset between edges at ptr 9.
    run_to_step(9, 40);
    #2 reset = 1'b1;
    #1;
    chk("areset_ptr", 32'(ptr), 32'h0);
    chk("areset_chars", 32'({char3, char2, char1, char0}), 32'h0123);
    chk("areset_step", 32'(step), 32'h0);
    #1 reset = 1'b0;
    @(negedge clk);
    run_to_step(3, 40);
    tick();
    chk("areset_mem", 32'({char3, char2, char1, char0}), 32'h3456);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      pause   = ($urandom_range(0, 3) == 0);
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_addr = 4'($urandom_range(0, 15));
      wr_data = 4'($urandom_range(0, 15));
      tick();
    end
    wr_en = 1'b0;
    pause = 1'b0;

`ifdef LED_SCROLL_DIR_EN
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    dir = 1'b1;
    repeat (STEP) tick();
    chk("dir_ptr", 32'(ptr), 32'hF);
    tick();
    chk("dir_chars", 32'({char3, char2, char1, char0}), 32'hF012);
    dir = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
